// File: rtl/imm_pkg.sv
// Shared immediate-format definitions and the immediate extender used by
// the decode stage and the compressed-instruction expander.
package imm_pkg;

   localparam int unsigned IMM_SRC_W = 3;
   localparam int unsigned IMM_MAX_W = 64;

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_U = 3'b011,
      IMM_J = 3'b100,
      IMM_Z = 3'b101
   } imm_src_e;

   // Full-width result; callers keep the low XLEN bits.
   function automatic logic [IMM_MAX_W-1:0] imm_extend(input logic [31:0]          instr,
                                                        input logic [IMM_SRC_W-1:0] src);
      logic [IMM_MAX_W-1:0] imm;
      imm = '0;
      case (src)
         IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
         IMM_J:   imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_Z:   imm = {59'b0, instr[19:15]};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   function automatic logic imm_src_illegal(input logic [IMM_SRC_W-1:0] src);
      return src[2] & src[1];
   endfunction

endpackage

// File: rtl/imm_pipe_slot.sv
// One elastic register slot: holds a single payload, loads when empty or
// when its current contents leave in the same cycle.
module imm_pipe_slot #(
   parameter int unsigned Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   logic             valid_d, valid_q;
   logic [Width-1:0] data_d, data_q;
   logic             can_load;

   always_comb begin
      can_load = !valid_q || out_ready_i;
      valid_d  = valid_q;
      data_d   = data_q;
      if (can_load) begin
         valid_d = in_valid_i;
         if (in_valid_i) begin
            data_d = in_data_i;
         end
      end
      if (flush_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready_o  = can_load;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/imm_decode_stage.sv
// Decodes the immediate at the input and carries it, with its tag, through
// a chain of STAGES elastic slots toward the execute-operand mux.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 1,
   parameter int unsigned TAG_W  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [31:0]          Instr_i,
   input  logic [IMM_SRC_W-1:0] ImmSrc_i,
   input  logic [TAG_W-1:0]     Tag_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [XLEN-1:0]      ImmExt_o,
   output logic [TAG_W-1:0]     Tag_o,
   output logic                 Illegal_o
);

   localparam int unsigned PayW = XLEN + TAG_W + 1;

   logic [IMM_MAX_W-1:0] imm_full;
   logic [XLEN-1:0]      imm_d;
   logic                 illegal_d;

   assign imm_full  = imm_extend(Instr_i, ImmSrc_i);
   assign illegal_d = imm_src_illegal(ImmSrc_i);

   if (XLEN < IMM_MAX_W) begin : g_trunc
      logic unused_imm_hi;
      assign unused_imm_hi = ^imm_full[IMM_MAX_W-1:XLEN];
      assign imm_d         = imm_full[XLEN-1:0];
   end else begin : g_full
      assign imm_d = imm_full;
   end

   // Index g is the link feeding slot g; index STAGES is the block output.
   logic [STAGES:0] vld;
   logic [STAGES:0] rdy;
   logic [PayW-1:0] pay [0:STAGES];

   assign vld[0]      = valid_i && !flush_i;
   assign pay[0]      = {illegal_d, Tag_i, imm_d};
   assign rdy[STAGES] = ready_i;

   for (genvar g = 0; g < STAGES; g++) begin : g_slot
      imm_pipe_slot #(
         .Width (PayW)
      ) u_slot (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .flush_i     (flush_i),
         .in_valid_i  (vld[g]),
         .in_ready_o  (rdy[g]),
         .in_data_i   (pay[g]),
         .out_valid_o (vld[g+1]),
         .out_ready_i (rdy[g+1]),
         .out_data_o  (pay[g+1])
      );
   end

   assign ready_o                         = rdy[0] && !flush_i;
   assign valid_o                         = vld[STAGES];
   assign {Illegal_o, Tag_o, ImmExt_o}    = pay[STAGES];

endmodule
